// File: rtl/booth_dot_accumulator_if.sv
// Handshake bundle between the Booth multiplier, the dot-product
// accumulator and the result consumer.
interface booth_dot_accumulator_if #(
    parameter int PWIDTH = 10,
    parameter int AWIDTH = 16
);
    logic                     start;
    logic signed [PWIDTH-1:0] prod;
    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [AWIDTH-1:0] acc_out;
    logic                     acc_valid;
    logic                     acc_ready;
    logic                     ovf;
    logic                     busy;

    modport master (
        output start, prod, prod_valid, acc_ready,
        input  prod_ready, acc_out, acc_valid, ovf, busy
    );

    modport slave (
        input  start, prod, prod_valid, acc_ready,
        output prod_ready, acc_out, acc_valid, ovf, busy
    );
endinterface

// File: rtl/booth_dot_accumulator.sv
// Accumulates NTERMS signed Booth products into a dot product with
// optional saturation, a sticky overflow flag and a valid/ready result.
module booth_dot_accumulator #(
    parameter int PWIDTH = 10,
    parameter int AWIDTH = 16,
    parameter int NTERMS = 4,
    parameter bit SAT    = 1'b1
) (
    input logic                     clk,
    input logic                     rst,
    booth_dot_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(NTERMS - 1);
    localparam logic [AWIDTH-1:0] MAXV = {1'b0, {(AWIDTH-1){1'b1}}};
    localparam logic [AWIDTH-1:0] MINV = {1'b1, {(AWIDTH-1){1'b0}}};

    state_t                   state_q, state_d;
    logic signed [AWIDTH-1:0] acc_q, acc_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic                     prod_ready_q;
    logic                     acc_valid_q;
    logic                     busy_q;

    logic                     accept;
    logic signed [AWIDTH:0]   sum;
    logic                     ovf_now;

    assign accept = bus.prod_valid & prod_ready_q;

    // One extra bit makes signed overflow visible as a sign disagreement
    assign sum = {acc_q[AWIDTH-1], acc_q}
               + {{(AWIDTH+1-PWIDTH){bus.prod[PWIDTH-1]}}, bus.prod};
    assign ovf_now = sum[AWIDTH] ^ sum[AWIDTH-1];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (ovf_now && SAT)
                        acc_d = sum[AWIDTH] ? MINV : MAXV;
                    else
                        acc_d = sum[AWIDTH-1:0];
                    ovf_d = ovf_q | ovf_now;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST)
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.acc_ready) begin
                    if (bus.start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= (state_d == ACCUM);
            acc_valid_q  <= (state_d == HOLD);
            busy_q       <= (state_d == ACCUM);
        end
    end

    assign bus.prod_ready = prod_ready_q;
    assign bus.acc_out    = acc_q;
    assign bus.acc_valid  = acc_valid_q;
    assign bus.ovf        = ovf_q;
    assign bus.busy       = busy_q;
endmodule
